// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, types and helpers for the UART byte-to-word path
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    // Generic occupancy count, wide enough for any practical word buffer
    typedef logic [7:0] fill_t;

    function automatic int bytes_per_word(input int w);
        return w / UART_BYTE_W;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with a registered head word and occupancy count
module sync_fifo_fwft
    import uart_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_nxt;

    assign o_full   = r_count == CNT_W'(DEPTH);
    assign o_empty  = r_count == '0;
    assign w_pop    = i_pop & ~o_empty;
    assign w_push   = i_push & (~o_full | w_pop);
    assign w_rd_nxt = r_rd + PTR_W'(1);
    assign o_data   = r_head;
    assign o_count  = r_count;

    // Storage: written on every accepted push; contents are meaningless until counted
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    // Pointers wrap naturally; full/empty come from the count, not pointer compare
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + PTR_W'(1);
            if (w_pop)
                r_rd <= w_rd_nxt;
            if (w_push != w_pop)
                r_count <= w_push ? r_count + CNT_W'(1) : r_count - CNT_W'(1);
        end
    end

    // Head word only moves on a pop or when a push lands in an empty (or emptying) FIFO
    always_ff @(posedge clk) begin
        if (!rst)
            r_head <= '0;
        else if (w_pop && r_count > CNT_W'(1))
            r_head <= r_mem[w_rd_nxt];
        else if (w_push && (o_empty || w_pop))
            r_head <= i_data;
    end

endmodule

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs UART bytes into words and buffers them behind a valid/ready port
module uart_word_assembler
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH     = 16,
    parameter bit BIG_ENDIAN     = 1'b0,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_uart_byte_ready,
    input  logic [UART_BYTE_W-1:0]          i_uart_byte,
    output logic [WORD_WIDTH-1:0]           o_word_data,
    output logic                            o_word_valid,
    input  logic                            i_word_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fill_level,
    output logic                            o_overflow,
    output logic                            o_timeout_err
);

    localparam int BPW    = bytes_per_word(WORD_WIDTH);
    localparam int K_W    = $clog2(BPW);
    localparam int IDLE_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [K_W-1:0]    K_LAST   = K_W'(BPW - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    logic [1:0]            r_hist;
    logic [K_W-1:0]        r_k;
    logic [WORD_WIDTH-1:0] r_asm;
    logic [IDLE_W-1:0]     r_idle;
    logic                  r_ovf;
    logic                  r_to;

    logic                  w_evt;
    logic                  w_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_timeout;
    logic [K_W-1:0]        w_lane;
    logic [WORD_WIDTH-1:0] w_merged;

    assign w_evt        = r_hist == 2'b01;
    assign w_last       = r_k == K_LAST;
    assign w_push       = w_evt & w_last;
    assign w_pop        = o_word_valid & i_word_ready;
    assign w_lane       = BIG_ENDIAN ? K_LAST - r_k : r_k;
    assign w_timeout    = (TIMEOUT_CYCLES > 0) && !w_evt && (r_k != '0) && (r_idle == IDLE_MAX);
    assign o_word_valid = ~w_empty;
    assign o_overflow   = r_ovf;
    assign o_timeout_err = r_to;

    // Drop the incoming byte into its lane, leaving the other lanes untouched
    always_comb begin
        w_merged = r_asm;
        w_merged[w_lane*UART_BYTE_W +: UART_BYTE_W] = i_uart_byte;
    end

    // Ready history; reset to 11 so a level already high at release is not a new byte
    always_ff @(posedge clk) begin
        if (!rst)
            r_hist <= 2'b11;
        else
            r_hist <= {r_hist[0], i_uart_byte_ready};
    end

    // Byte index and assembly register; a byte event beats a same-cycle timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_k   <= '0;
            r_asm <= '0;
        end else if (w_evt) begin
            r_asm <= w_merged;
            r_k   <= w_last ? '0 : r_k + K_W'(1);
        end else if (w_timeout) begin
            r_k   <= '0;
            r_asm <= '0;
        end
    end

    // Idle counter: runs only while a word is partially assembled, saturates at the limit
    always_ff @(posedge clk) begin
        if (!rst || w_evt || w_timeout)
            r_idle <= '0;
        else if (TIMEOUT_CYCLES > 0 && r_k != '0 && r_idle != IDLE_MAX)
            r_idle <= r_idle + IDLE_W'(1);
    end

    // Single-cycle error pulses: dropped word on a full FIFO, discarded partial word
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_to  <= 1'b0;
        end else begin
            r_ovf <= w_push & w_full & ~w_pop;
            r_to  <= w_timeout;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_merged),
        .i_pop   (w_pop),
        .o_data  (o_word_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fill_level)
    );

endmodule

// File: tb/tb_uart_word_assembler.sv
// tb_uart_word_assembler: model-checked bench for a 16-bit LE (timeout 50) and a 32-bit BE instance
module tb_uart_word_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_rdy, a_wr, b_rdy, b_wr;
    logic [7:0]  a_byte, b_byte;
    logic [15:0] a_data;
    logic [31:0] b_data;
    logic        a_valid, b_valid, a_ovf, b_ovf, a_to, b_to;
    logic [2:0]  a_fill, b_fill;

    uart_word_assembler #(
        .WORD_WIDTH(16), .BIG_ENDIAN(1'b0), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(50)
    ) dut_a (
        .clk(clk), .rst(rst),
        .i_uart_byte_ready(a_rdy), .i_uart_byte(a_byte),
        .o_word_data(a_data), .o_word_valid(a_valid), .i_word_ready(a_wr),
        .o_fill_level(a_fill), .o_overflow(a_ovf), .o_timeout_err(a_to)
    );

    uart_word_assembler #(
        .WORD_WIDTH(32), .BIG_ENDIAN(1'b1), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .i_uart_byte_ready(b_rdy), .i_uart_byte(b_byte),
        .o_word_data(b_data), .o_word_valid(b_valid), .i_word_ready(b_wr),
        .o_fill_level(b_fill), .o_overflow(b_ovf), .o_timeout_err(b_to)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        else
            n_pass++;
    endtask

    function automatic int bpw(input int d);
        return d == 0 ? 2 : 4;
    endfunction

    function automatic bit be(input int d);
        return d == 1;
    endfunction

    function automatic int tmo(input int d);
        return d == 0 ? 50 : 0;
    endfunction

    // Behavioural model: per instance, a list of received bytes and a queue of finished words
    logic [1:0]  m_hist [2];
    logic [7:0]  m_pb   [2][4];
    int          m_pn   [2];
    int          m_idle [2];
    logic [31:0] m_q    [2][8];
    int          m_n    [2];
    logic        m_ovf  [2];
    logic        m_to   [2];
    bit          m_on = 1'b0;
    logic        mr, mw, mevt, mpop, mpush;
    logic [7:0]  mb;
    logic [31:0] mword;

    function automatic logic [31:0] pack(input int d);
        logic [31:0] w = '0;
        for (int i = 0; i < bpw(d); i++)
            w = be(d) ? ((w << 8) | 32'(m_pb[d][i])) : (w | (32'(m_pb[d][i]) << (8 * i)));
        return w;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mr = d == 0 ? a_rdy : b_rdy;
            mw = d == 0 ? a_wr : b_wr;
            mb = d == 0 ? a_byte : b_byte;
            m_ovf[d] = 1'b0;
            m_to[d] = 1'b0;
            if (!rst) begin
                m_hist[d] = 2'b11;
                m_pn[d] = 0;
                m_idle[d] = 0;
                m_n[d] = 0;
                m_on = 1'b1;
            end else begin
                mevt = m_hist[d] == 2'b01;
                m_hist[d] = {m_hist[d][0], mr};
                mpop = m_n[d] > 0 && mw;
                mpush = 1'b0;
                if (mevt) begin
                    m_pb[d][m_pn[d]] = mb;
                    m_pn[d]++;
                    m_idle[d] = 0;
                    if (m_pn[d] == bpw(d)) begin
                        mword = pack(d);
                        mpush = 1'b1;
                        m_pn[d] = 0;
                    end
                end else if (tmo(d) > 0 && m_pn[d] > 0) begin
                    if (m_idle[d] == tmo(d)) begin
                        m_pn[d] = 0;
                        m_idle[d] = 0;
                        m_to[d] = 1'b1;
                    end else
                        m_idle[d]++;
                end
                if (mpop) begin
                    for (int i = 0; i < 7; i++)
                        m_q[d][i] = m_q[d][i+1];
                    m_n[d]--;
                end
                if (mpush) begin
                    if (m_n[d] < 4) begin
                        m_q[d][m_n[d]] = mword;
                        m_n[d]++;
                    end else
                        m_ovf[d] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (m_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("valid%0d", d), d == 0 ? 32'(a_valid) : 32'(b_valid), 32'(m_n[d] > 0));
                chk($sformatf("fill%0d", d), d == 0 ? 32'(a_fill) : 32'(b_fill), m_n[d]);
                chk($sformatf("overflow%0d", d), d == 0 ? 32'(a_ovf) : 32'(b_ovf), 32'(m_ovf[d]));
                chk($sformatf("timeout%0d", d), d == 0 ? 32'(a_to) : 32'(b_to), 32'(m_to[d]));
                if (m_n[d] > 0)
                    chk($sformatf("data%0d", d), d == 0 ? 32'(a_data) : b_data, m_q[d][0]);
            end
        end
    end

    // Words popped from instance A and pulse tallies, for the literal checks
    logic [15:0] pa [$];
    int n_ovf = 0;
    int n_to = 0;
    always @(posedge clk) begin
        if (a_valid && a_wr)
            pa.push_back(a_data);
        if (a_ovf)
            n_ovf++;
        if (a_to)
            n_to++;
    end

    task automatic send_a(input logic [7:0] v, input bit pop_at_capture = 1'b0);
        a_byte = v;
        a_rdy = 1'b1;
        @(negedge clk);
        if (pop_at_capture)
            a_wr = 1'b1;
        @(negedge clk);
        a_rdy = 1'b0;
        if (pop_at_capture)
            a_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] v);
        b_byte = v;
        b_rdy = 1'b1;
        repeat (2) @(negedge clk);
        b_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain_a();
        a_wr = 1'b1;
        repeat (6) @(negedge clk);
        a_wr = 1'b0;
    endtask

    int base;

    initial begin
        rst = 1'b0;
        a_rdy = 1'b1;
        a_byte = 8'h55;
        a_wr = 1'b0;
        b_rdy = 1'b0;
        b_byte = 8'h00;
        b_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(a_valid), 0);
        chk("reset_fill", 32'(a_fill), 0);
        chk("reset_data_a", 32'(a_data), 0);
        chk("reset_data_b", b_data, 0);
        chk("reset_pulses", {a_ovf, a_to, b_ovf, b_to}, 0);

        // Ready held high across reset release must not produce a byte
        rst = 1'b1;
        repeat (5) @(negedge clk);
        a_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_ready_fill", 32'(a_fill), 0);
        chk("held_ready_pops", pa.size(), 0);

        // 16-bit little-endian word, consumer always ready
        a_wr = 1'b1;
        send_a(8'h34);
        send_a(8'h12);
        repeat (3) @(negedge clk);
        chk("le16_beats", pa.size(), 1);
        chk("le16_word", 32'(pa[0]), 32'h1234);
        a_wr = 1'b0;

        // 32-bit big-endian word, fill 0 -> 1 -> 0
        send_b(8'hDE);
        send_b(8'hAD);
        send_b(8'hBE);
        chk("be32_fill_before", 32'(b_fill), 0);
        send_b(8'hEF);
        chk("be32_fill_after", 32'(b_fill), 1);
        chk("be32_word", b_data, 32'hDEADBEEF);
        b_wr = 1'b1;
        @(negedge clk);
        b_wr = 1'b0;
        @(negedge clk);
        chk("be32_fill_popped", 32'(b_fill), 0);

        // Five words into a stalled 4-deep FIFO
        pa.delete();
        base = n_ovf;
        for (int i = 1; i <= 5; i++) begin
            send_a(8'(i));
            send_a(8'hA0);
        end
        repeat (2) @(negedge clk);
        chk("ovf_fill", 32'(a_fill), 4);
        chk("ovf_pulses", n_ovf - base, 1);
        drain_a();
        chk("ovf_drained", pa.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ovf_order%0d", i), 32'(pa[i]), 32'hA001 + i);

        // Full FIFO with a pop on the edge the last byte lands
        pa.delete();
        base = n_ovf;
        for (int i = 1; i <= 4; i++) begin
            send_a(8'(i));
            send_a(8'hB0);
        end
        send_a(8'h05);
        send_a(8'hB0, 1'b1);
        repeat (2) @(negedge clk);
        chk("fullpop_fill", 32'(a_fill), 4);
        chk("fullpop_no_ovf", n_ovf - base, 0);
        drain_a();
        chk("fullpop_count", pa.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fullpop_order%0d", i), 32'(pa[i]), 32'hB001 + i);

        // Abandoned partial word discarded after 50 idle cycles
        pa.delete();
        base = n_to;
        a_wr = 1'b1;
        send_a(8'h99);
        repeat (60) @(negedge clk);
        chk("timeout_pulses", n_to - base, 1);
        chk("timeout_no_word", pa.size(), 0);
        send_a(8'h78);
        send_a(8'h56);
        repeat (3) @(negedge clk);
        chk("after_timeout_count", pa.size(), 1);
        chk("after_timeout_word", 32'(pa[0]), 32'h5678);
        a_wr = 1'b0;

        // Reset mid-word on A and with a buffered word on B
        send_b(8'h11);
        send_b(8'h22);
        send_b(8'h33);
        send_b(8'h44);
        chk("pre_reset_b_fill", 32'(b_fill), 1);
        send_a(8'hAB);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_a_fill", 32'(a_fill), 0);
        chk("midrst_a_data", 32'(a_data), 0);
        chk("midrst_b_fill", 32'(b_fill), 0);
        chk("midrst_b_data", b_data, 0);
        chk("midrst_flags", {a_valid, b_valid, a_ovf, a_to}, 0);
        rst = 1'b1;
        pa.delete();
        a_wr = 1'b1;
        repeat (2) @(negedge clk);
        send_a(8'hCD);
        send_a(8'hEF);
        repeat (3) @(negedge clk);
        chk("postrst_count", pa.size(), 1);
        chk("postrst_word", 32'(pa[0]), 32'hEFCD);
        a_wr = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
